// File: rtl/time_set_demux_pkg.sv
// Shared types and helpers for the alarm-clock set/display demultiplexer.
//   state_e     : UI state encoding (RUN and the four set states)
//   field_e     : edit_field codes driven to the display blink logic
//   inc_pulse_t : one bit per increment destination
package time_set_demux_pkg;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_T_HR  = 3'd1,
        ST_T_MIN = 3'd2,
        ST_A_HR  = 3'd3,
        ST_A_MIN = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        FIELD_NONE = 2'd0,
        FIELD_HR   = 2'd1,
        FIELD_MIN  = 2'd2
    } field_e;

    typedef struct packed {
        logic time_hr;
        logic time_min;
        logic alm_hr;
        logic alm_min;
    } inc_pulse_t;

    // Mode button walks RUN -> T_HR -> T_MIN -> A_HR -> A_MIN -> RUN.
    function automatic state_e next_mode_state(input state_e s);
        case (s)
            ST_RUN:   return ST_T_HR;
            ST_T_HR:  return ST_T_MIN;
            ST_T_MIN: return ST_A_HR;
            ST_A_HR:  return ST_A_MIN;
            default:  return ST_RUN;
        endcase
    endfunction

    function automatic field_e field_of(input state_e s);
        case (s)
            ST_T_HR, ST_A_HR:   return FIELD_HR;
            ST_T_MIN, ST_A_MIN: return FIELD_MIN;
            default:            return FIELD_NONE;
        endcase
    endfunction

    function automatic logic is_alarm_state(input state_e s);
        return (s == ST_A_HR) || (s == ST_A_MIN);
    endfunction

    // Increment destination selected by a set state; RUN selects nothing.
    function automatic inc_pulse_t pulse_for(input state_e s);
        inc_pulse_t p;
        p = '0;
        case (s)
            ST_T_HR:  p.time_hr  = 1'b1;
            ST_T_MIN: p.time_min = 1'b1;
            ST_A_HR:  p.alm_hr   = 1'b1;
            ST_A_MIN: p.alm_min  = 1'b1;
            default:  p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/time_set_demux_if.sv
// Button/strobe inputs and set/display outputs of time_set_demux.
//   master : drives tick_in, btn_mode, btn_inc; observes the outputs
//   slave  : the demux itself
interface time_set_demux_if;

    logic       tick_in;
    logic       btn_mode;
    logic       btn_inc;
    logic       inc_time_hr;
    logic       inc_time_min;
    logic       inc_alm_hr;
    logic       inc_alm_min;
    logic       alarm_en;
    logic       show_alarm;
    logic [1:0] edit_field;

    modport master (
        output tick_in, btn_mode, btn_inc,
        input  inc_time_hr, inc_time_min, inc_alm_hr, inc_alm_min,
        input  alarm_en, show_alarm, edit_field
    );

    modport slave (
        input  tick_in, btn_mode, btn_inc,
        output inc_time_hr, inc_time_min, inc_alm_hr, inc_alm_min,
        output alarm_en, show_alarm, edit_field
    );

endinterface

// File: rtl/time_set_demux_btn_sync_edge.sv
// Raw push-button conditioning: 2-flop synchronizer plus registered rising-edge detector.
//   clk, rst_n : clock, async active-low reset
//   btn_i      : raw asynchronous button
//   rise_o     : one-cycle strobe, high in the cycle after the third edge following a press
//   level_o    : synchronized button level, aligned with rise_o
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o,
    output logic level_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;

    // Synchronizer, delayed copy and registered edge strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign rise_o  = rise_q;
    assign level_o = prev_q;

endmodule

// File: rtl/time_set_demux.sv
// Routes the shared mode/inc buttons to the four time/alarm increment pulses,
// owns the alarm-armed flag and drives the display source/blink selects.
//   clk, rst_n : clock, async active-low reset
//   bus.slave  : tick_in, btn_mode, btn_inc in; inc_* pulses, alarm_en,
//                show_alarm, edit_field out (all registered)
module time_set_demux
    import time_set_demux_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 5,
    parameter int unsigned REPEAT_RATE  = 2,
    parameter int unsigned TIMEOUT      = 100
) (
    input  logic           clk,
    input  logic           rst_n,
    time_set_demux_if.slave bus
);

    localparam int unsigned MAX_RD    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned MAX_PARAM = (MAX_RD > TIMEOUT) ? MAX_RD : TIMEOUT;
    localparam int unsigned CNT_W     = $clog2(MAX_PARAM) + 1;

    localparam logic [CNT_W-1:0] DELAY_C   = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_C    = CNT_W'(REPEAT_RATE);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    logic mode_rise;
    logic mode_level;
    logic inc_rise;
    logic inc_level;

    btn_sync_edge u_mode (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (bus.btn_mode),
        .rise_o  (mode_rise),
        .level_o (mode_level)
    );

    btn_sync_edge u_inc (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (bus.btn_inc),
        .rise_o  (inc_rise),
        .level_o (inc_level)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_run_q, rep_run_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             alarm_en_q, alarm_en_d;
    inc_pulse_t       inc_q, inc_d;
    field_e           edit_q;
    logic             show_q;

    logic             fire;
    logic [CNT_W-1:0] rep_limit;
    logic [CNT_W-1:0] rep_next;

    // Next-state, counters and pulse request.
    always_comb begin
        state_d    = state_q;
        rep_cnt_d  = rep_cnt_q;
        rep_run_d  = rep_run_q;
        to_cnt_d   = to_cnt_q;
        alarm_en_d = alarm_en_q;
        inc_d      = '0;
        fire       = 1'b0;
        rep_limit  = rep_run_q ? RATE_C : DELAY_C;
        rep_next   = sat_inc(rep_cnt_q);

        if (mode_rise) begin
            // Mode beats a coincident inc edge; the inc press is dropped.
            state_d   = next_mode_state(state_q);
            rep_cnt_d = '0;
            rep_run_d = 1'b0;
            to_cnt_d  = '0;
        end else if (inc_rise) begin
            rep_cnt_d = '0;
            rep_run_d = 1'b0;
            to_cnt_d  = '0;
            if (state_q == ST_RUN) begin
                alarm_en_d = ~alarm_en_q;
            end else begin
                fire = 1'b1;
            end
        end else if (state_q == ST_RUN) begin
            rep_cnt_d = '0;
            rep_run_d = 1'b0;
            to_cnt_d  = '0;
        end else begin
            // Auto-repeat: first pulse after REPEAT_DELAY ticks, then every REPEAT_RATE.
            if (!inc_level) begin
                rep_cnt_d = '0;
                rep_run_d = 1'b0;
            end else if (bus.tick_in) begin
                if (rep_next >= rep_limit) begin
                    fire      = 1'b1;
                    rep_cnt_d = '0;
                    rep_run_d = 1'b1;
                end else begin
                    rep_cnt_d = rep_next;
                end
            end

            // Inactivity timeout; a held button counts as activity.
            if (inc_level || mode_level) begin
                to_cnt_d = '0;
            end else if (to_cnt_q >= TIMEOUT_C) begin
                state_d  = ST_RUN;
                to_cnt_d = '0;
            end else if (bus.tick_in) begin
                to_cnt_d = sat_inc(to_cnt_q);
            end
        end

        if (fire) begin
            inc_d = pulse_for(state_q);
        end
    end

    // State, counters and registered outputs; display selects track state_d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            rep_cnt_q  <= '0;
            rep_run_q  <= 1'b0;
            to_cnt_q   <= '0;
            alarm_en_q <= 1'b0;
            inc_q      <= '0;
            edit_q     <= FIELD_NONE;
            show_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rep_cnt_q  <= rep_cnt_d;
            rep_run_q  <= rep_run_d;
            to_cnt_q   <= to_cnt_d;
            alarm_en_q <= alarm_en_d;
            inc_q      <= inc_d;
            edit_q     <= field_of(state_d);
            show_q     <= is_alarm_state(state_d);
        end
    end

    assign bus.inc_time_hr  = inc_q.time_hr;
    assign bus.inc_time_min = inc_q.time_min;
    assign bus.inc_alm_hr   = inc_q.alm_hr;
    assign bus.inc_alm_min  = inc_q.alm_min;
    assign bus.alarm_en     = alarm_en_q;
    assign bus.show_alarm   = show_q;
    assign bus.edit_field   = edit_q;

endmodule
